// File: rtl/square_table_ctrl_pkg.sv
// Shared widths, table depth and FSM state encoding for the square table sequencer.
package square_pkg;

    localparam int VAL_W       = 6;
    localparam int SQ_W        = 12;
    localparam int WORD_W      = 16;
    localparam int TABLE_DEPTH = 1 << VAL_W;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FILL    = 3'd1,
        DUMP_HI = 3'd2,
        DUMP_LO = 3'd3,
        CSUM_HI = 3'd4,
        CSUM_LO = 3'd5
    } state_t;

    // States in which a byte is offered to the sink.
    function automatic logic is_byte_state(input state_t st);
        return (st == DUMP_HI) || (st == DUMP_LO) || (st == CSUM_HI) || (st == CSUM_LO);
    endfunction

endpackage

// File: rtl/square_table_ctrl_square_cal.sv
// Combinational squarer: square = value * value, full precision.
module square_cal #(
    parameter int VAL_W = 6,
    parameter int SQ_W  = 12
) (
    input  logic [VAL_W-1:0] value,
    output logic [SQ_W-1:0]  square
);

    assign square = SQ_W'(value) * SQ_W'(value);

endmodule

// File: rtl/square_table_ctrl.sv
// Sweeps every input through square_cal into a table, then streams it out high byte first.
// Build option SQUARE_TABLE_CHECKSUM_EN appends a 16-bit sum of all table words.
module square_table_ctrl
    import square_pkg::*;
#(
    parameter int VAL_W  = square_pkg::VAL_W,
    parameter int SQ_W   = square_pkg::SQ_W,
    parameter int WORD_W = square_pkg::WORD_W
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    input  logic       byte_ready,
    output logic       byte_last
);

    localparam int DEPTH = 1 << VAL_W;
    localparam logic [VAL_W-1:0] LAST_IDX = VAL_W'(DEPTH - 1);

    state_t             state_r, state_next_s;
    logic [VAL_W-1:0]   idx_r, idx_next_s;
    logic [SQ_W-1:0]    square_s;
    logic [WORD_W-1:0]  word_s;
    logic [WORD_W-1:0]  rd_word_s;
    logic [WORD_W-1:0]  table_mem_r [DEPTH];
    logic               wr_en_s;
    logic               busy_r, byte_valid_r, byte_last_r, done_r;
    logic               done_next_s, last_next_s;
`ifdef SQUARE_TABLE_CHECKSUM_EN
    logic [WORD_W-1:0]  csum_r, csum_next_s;
`endif

    square_cal #(.VAL_W(VAL_W), .SQ_W(SQ_W)) u_square_cal (
        .value  (idx_r),
        .square (square_s)
    );

    assign word_s    = WORD_W'(square_s);
    assign rd_word_s = table_mem_r[idx_r];

    // Next-state, counter, checksum and done decode.
    always_comb begin
        state_next_s = state_r;
        idx_next_s   = idx_r;
        done_next_s  = 1'b0;
        wr_en_s      = 1'b0;
`ifdef SQUARE_TABLE_CHECKSUM_EN
        csum_next_s  = csum_r;
`endif
        case (state_r)
            IDLE: begin
                // The done cycle is still IDLE; a start there is deliberately dropped.
                if (start && !done_r) begin
                    state_next_s = FILL;
                    idx_next_s   = '0;
`ifdef SQUARE_TABLE_CHECKSUM_EN
                    csum_next_s  = '0;
`endif
                end else begin
                    state_next_s = IDLE;
                end
            end
            FILL: begin
                wr_en_s = 1'b1;
`ifdef SQUARE_TABLE_CHECKSUM_EN
                csum_next_s = csum_r + word_s;
`endif
                if (idx_r == LAST_IDX) begin
                    state_next_s = DUMP_HI;
                    idx_next_s   = '0;
                end else begin
                    idx_next_s = idx_r + VAL_W'(1);
                end
            end
            DUMP_HI: begin
                if (byte_ready) begin
                    state_next_s = DUMP_LO;
                end else begin
                    state_next_s = DUMP_HI;
                end
            end
            DUMP_LO: begin
                if (byte_ready) begin
                    if (idx_r == LAST_IDX) begin
`ifdef SQUARE_TABLE_CHECKSUM_EN
                        state_next_s = CSUM_HI;
`else
                        state_next_s = IDLE;
                        done_next_s  = 1'b1;
`endif
                    end else begin
                        state_next_s = DUMP_HI;
                        idx_next_s   = idx_r + VAL_W'(1);
                    end
                end else begin
                    state_next_s = DUMP_LO;
                end
            end
`ifdef SQUARE_TABLE_CHECKSUM_EN
            CSUM_HI: begin
                if (byte_ready) begin
                    state_next_s = CSUM_LO;
                end else begin
                    state_next_s = CSUM_HI;
                end
            end
            CSUM_LO: begin
                if (byte_ready) begin
                    state_next_s = IDLE;
                    done_next_s  = 1'b1;
                end else begin
                    state_next_s = CSUM_LO;
                end
            end
`endif
            default: begin
                state_next_s = IDLE;
                idx_next_s   = '0;
            end
        endcase
    end

    // Marks the final byte of a run in the state about to be entered.
`ifdef SQUARE_TABLE_CHECKSUM_EN
    assign last_next_s = (state_next_s == CSUM_LO);
`else
    assign last_next_s = (state_next_s == DUMP_LO) && (idx_next_s == LAST_IDX);
`endif

    // State, counter and registered handshake flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            idx_r        <= '0;
            busy_r       <= 1'b0;
            byte_valid_r <= 1'b0;
            byte_last_r  <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            idx_r        <= idx_next_s;
            busy_r       <= (state_next_s != IDLE);
            byte_valid_r <= is_byte_state(state_next_s);
            byte_last_r  <= last_next_s;
            done_r       <= done_next_s;
        end
    end

`ifdef SQUARE_TABLE_CHECKSUM_EN
    // Running sum of stored words, wrapping at 16 bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            csum_r <= '0;
        end else begin
            csum_r <= csum_next_s;
        end
    end
`endif

    // Table storage; contents survive reset on purpose.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            table_mem_r[idx_r] <= word_s;
        end
    end

    // Byte selection from the registered state; read is asynchronous so data tracks the state.
    always_comb begin
        byte_data = 8'h00;
        case (state_r)
            DUMP_HI: byte_data = rd_word_s[15:8];
            DUMP_LO: byte_data = rd_word_s[7:0];
`ifdef SQUARE_TABLE_CHECKSUM_EN
            CSUM_HI: byte_data = csum_r[15:8];
            CSUM_LO: byte_data = csum_r[7:0];
`endif
            default: byte_data = 8'h00;
        endcase
    end

    assign busy       = busy_r;
    assign byte_valid = byte_valid_r;
    assign byte_last  = byte_last_r;
    assign done       = done_r;

endmodule

// File: tb/tb_square_table_ctrl.sv
// Scoreboard bench for square_table_ctrl: expected bytes queued by stimulus, checked by a monitor.
module tb_square_table_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       busy;
    logic       done;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic       byte_ready = 1'b0;
    logic       byte_last;

`ifdef SQUARE_TABLE_CHECKSUM_EN
    localparam int NBYTES = 130;
`else
    localparam int NBYTES = 128;
`endif

    square_table_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .byte_last  (byte_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic       l;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   acc_cnt = 0;
    int   run_bytes = 0;
    int   done_cnt = 0;
    int   last_cyc = -10;
    int   first_valid_cyc = 0;
    int   mode = 0;
    int   stall_left = 0;
    int   prev_acc = -1;
    bit   held = 1'b0;
    bit   prev_valid = 1'b0;
    logic [7:0] held_d;
    logic       held_l;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Sink ready: always high, or two stall cycles before each byte of entry 5.
    always @(posedge clk) begin
        #1;
        if (acc_cnt != prev_acc) begin
            stall_left = 2;
            prev_acc   = acc_cnt;
        end
        if (mode == 1 && (acc_cnt == 10 || acc_cnt == 11) && stall_left > 0) begin
            byte_ready = 1'b0;
            stall_left--;
        end else begin
            byte_ready = 1'b1;
        end
    end

    // Monitor: pops the scoreboard on each accepted byte and checks hold/done behaviour.
    always @(negedge clk) begin
        if (reset) begin
            acc_cnt    = 0;
            held       = 1'b0;
            prev_valid = 1'b0;
        end else begin
            if (held) begin
                check("hold_valid", 32'(byte_valid), 32'd1);
                check("hold_data", 32'(byte_data), 32'(held_d));
                check("hold_last", 32'(byte_last), 32'(held_l));
                held = 1'b0;
            end
            if (byte_valid && !prev_valid && acc_cnt == 0) first_valid_cyc = cyc;
            prev_valid = byte_valid;
            if (byte_valid && byte_ready) begin
                if (q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL extra_byte: got 0x%0h expected no byte", byte_data);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check($sformatf("byte%0d_data", acc_cnt), 32'(byte_data), 32'(e.d));
                    check($sformatf("byte%0d_last", acc_cnt), 32'(byte_last), 32'(e.l));
                end
                if (acc_cnt == 11)  check("entry5_lo", 32'(byte_data), 32'h19);
                if (acc_cnt == 126) check("entry63_hi", 32'(byte_data), 32'h0F);
                if (acc_cnt == 127) check("entry63_lo", 32'(byte_data), 32'h81);
                if (byte_last) last_cyc = cyc;
                acc_cnt++;
            end else if (byte_valid) begin
                held   = 1'b1;
                held_d = byte_data;
                held_l = byte_last;
            end
            if (done) begin
                done_cnt++;
                check("done_timing", 32'(cyc), 32'(last_cyc + 1));
                run_bytes = acc_cnt;
                acc_cnt   = 0;
            end
        end
    end

    task automatic push_run();
        for (int k = 0; k < 64; k++) begin
            logic [15:0] w;
            w = 16'(k * k);
            q.push_back('{d: w[15:8], l: 1'b0});
`ifdef SQUARE_TABLE_CHECKSUM_EN
            q.push_back('{d: w[7:0], l: 1'b0});
`else
            q.push_back('{d: w[7:0], l: (k == 63)});
`endif
        end
`ifdef SQUARE_TABLE_CHECKSUM_EN
        q.push_back('{d: 8'h4D, l: 1'b0});
        q.push_back('{d: 8'h60, l: 1'b1});
`endif
    endtask

    task automatic start_pulse(output int sc);
        @(posedge clk);
        #1;
        start = 1'b1;
        sc    = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_acc(input int n);
        int t = 0;
        while (acc_cnt < n && t < 3000) begin
            @(posedge clk);
            #2;
            t++;
        end
        check("wait_acc_timeout", 32'(acc_cnt >= n), 32'd1);
    endtask

    task automatic finish_run(input int d0, input int sc, input bit pulse_in_done);
        int t = 0;
        while (!done && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check("run_timeout", 32'(done), 32'd1);
        if (pulse_in_done) begin
            start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        repeat (100) @(negedge clk);
        check("done_count", 32'(done_cnt), 32'(d0 + 1));
        check("byte_count", 32'(run_bytes), 32'(NBYTES));
        check("queue_empty", 32'(q.size()), 32'd0);
        check("latency", 32'(first_valid_cyc - sc), 32'd65);
        check("idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        int sc;
        int d0;
        reset = 1'b1;
        start = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_done", 32'(done), 32'd0);
            check("rst_valid", 32'(byte_valid), 32'd0);
            check("rst_last", 32'(byte_last), 32'd0);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        start = 1'b0;
        repeat (3) @(posedge clk);

        // Plain run with the sink always ready.
        mode = 0;
        push_run();
        d0 = done_cnt;
        start_pulse(sc);
        finish_run(d0, sc, 1'b0);

        // Backpressure on entry 5.
        mode = 1;
        push_run();
        d0 = done_cnt;
        start_pulse(sc);
        finish_run(d0, sc, 1'b0);
        mode = 0;

        // Starts during FILL, DUMP_LO and the done cycle are all ignored.
        push_run();
        d0 = done_cnt;
        start_pulse(sc);
        repeat (10) @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_acc(21);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        finish_run(d0, sc, 1'b1);

        // Reset in the middle of the dump aborts the run without done.
        push_run();
        d0 = done_cnt;
        start_pulse(sc);
        wait_acc(40);
        reset = 1'b1;
        q.delete();
        repeat (3) begin
            @(negedge clk);
            check("mid_rst_valid", 32'(byte_valid), 32'd0);
            check("mid_rst_busy", 32'(busy), 32'd0);
            check("mid_rst_done", 32'(done), 32'd0);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("no_done_on_abort", 32'(done_cnt), 32'(d0));
        push_run();
        d0 = done_cnt;
        start_pulse(sc);
        finish_run(d0, sc, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
